// File: rtl/mem_stage.sv
// mem_stage: memory stage of the five-stage pipeline.
// Issues data-cache requests from the EX/MEM latch, holds the pipeline until
// dhit, keeps the LL/SC link register and owns the MEM/WB latch.
`timescale 1ns/1ps
module mem_stage #(
  parameter int WORD_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              CLK,
  input  logic              nrst,
  input  logic              ihit,
  input  logic              em_valid,
  input  logic [WORD_W-1:0] em_aluout,
  input  logic [WORD_W-1:0] em_store,
  input  logic [WORD_W-1:0] em_npc,
  input  logic [REG_W-1:0]  em_dest,
  input  logic              em_dren,
  input  logic              em_dwen,
  input  logic              em_ll,
  input  logic              em_sc,
  input  logic              em_regwen,
  input  logic              em_memtoreg,
  input  logic              em_jal,
  input  logic              em_halt,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dmemload,
  input  logic              llinv,
  input  logic [WORD_W-1:0] llinv_addr,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  output logic              mem_stall,
  output logic              mw_valid,
  output logic              mw_regwen,
  output logic              mw_halt,
  output logic [REG_W-1:0]  mw_dest,
  output logic [WORD_W-1:0] mw_wdat
);

  typedef enum logic {ACCESS = 1'b0, DONE = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   hold_data_q, hold_data_d;
  logic                link_valid_q, link_valid_d;
  logic [WORD_W-1:0]   link_addr_q, link_addr_d;

  logic                mw_valid_q, mw_valid_d;
  logic                mw_regwen_q, mw_regwen_d;
  logic                mw_halt_q, mw_halt_d;
  logic [REG_W-1:0]    mw_dest_q, mw_dest_d;
  logic [WORD_W-1:0]   mw_wdat_q, mw_wdat_d;

  logic                sc_ok;
  logic                rd_req;
  logic                wr_req;
  logic                mop;
  logic                advance;
  logic [WORD_W-1:0]   load_data;
  logic [WORD_W-1:0]   wdat_sel;

  // An SC only writes (and only waits on the cache) while the link still
  // covers its address; the decoder also raises em_dwen for SC, so the
  // plain-store term masks SC out to keep a failed SC from stalling.
  assign sc_ok   = link_valid_q & (link_addr_q == em_aluout);
  assign rd_req  = em_valid & em_dren;
  assign wr_req  = em_valid & ((em_dwen & ~em_sc) | (em_sc & sc_ok));
  assign mop     = rd_req | wr_req;

  assign mem_stall = mop & (state_q == ACCESS) & ~dhit;
  assign advance   = ihit & ~mem_stall;

  assign dmemaddr  = em_aluout;
  assign dmemstore = em_store;

  // Once the cache has answered, the data lives in hold_data until commit.
  assign load_data = (state_q == DONE) ? hold_data_q : dmemload;

  // Writeback data select: load, then link address, then SC flag, then ALU.
  always_comb begin
    wdat_sel = em_aluout;
    if (em_memtoreg)
      wdat_sel = load_data;
    else if (em_jal)
      wdat_sel = em_npc;
    else if (em_sc)
      wdat_sel = {{(WORD_W-1){1'b0}}, sc_ok};
  end

  // Access FSM: issue requests in ACCESS, park in DONE while waiting for ihit.
  always_comb begin
    state_d     = state_q;
    hold_data_d = hold_data_q;
    dmemREN     = 1'b0;
    dmemWEN     = 1'b0;
    case (state_q)
      ACCESS: begin
        dmemREN = rd_req;
        dmemWEN = wr_req;
        if (mop & dhit & ~ihit) begin
          state_d     = DONE;
          hold_data_d = dmemload;
        end
      end
      DONE: begin
        if (advance)
          state_d = ACCESS;
      end
    endcase
  end

  // Link register: invalidates apply every cycle, a committing LL overrides.
  always_comb begin
    link_valid_d = link_valid_q;
    link_addr_d  = link_addr_q;
    if (llinv && (llinv_addr == link_addr_q))
      link_valid_d = 1'b0;
    if (advance & em_valid) begin
      if (em_ll) begin
        link_valid_d = 1'b1;
        link_addr_d  = em_aluout;
      end else if (em_sc) begin
        link_valid_d = 1'b0;
      end else if (em_dwen && (em_aluout == link_addr_q)) begin
        link_valid_d = 1'b0;
      end
    end
  end

  // MEM/WB latch next state: load on advance, otherwise insert a bubble.
  always_comb begin
    mw_valid_d  = 1'b0;
    mw_regwen_d = 1'b0;
    mw_halt_d   = mw_halt_q;
    mw_dest_d   = mw_dest_q;
    mw_wdat_d   = mw_wdat_q;
    if (advance) begin
      mw_valid_d  = em_valid;
      mw_regwen_d = em_regwen & em_valid;
      mw_halt_d   = mw_halt_q | (em_halt & em_valid);
      mw_dest_d   = em_dest;
      mw_wdat_d   = wdat_sel;
    end
  end

  // State, link and MEM/WB registers with asynchronous reset.
  always_ff @(posedge CLK or negedge nrst) begin
    if (!nrst) begin
      state_q      <= ACCESS;
      hold_data_q  <= '0;
      link_valid_q <= 1'b0;
      link_addr_q  <= '0;
      mw_valid_q   <= 1'b0;
      mw_regwen_q  <= 1'b0;
      mw_halt_q    <= 1'b0;
      mw_dest_q    <= '0;
      mw_wdat_q    <= '0;
    end else begin
      state_q      <= state_d;
      hold_data_q  <= hold_data_d;
      link_valid_q <= link_valid_d;
      link_addr_q  <= link_addr_d;
      mw_valid_q   <= mw_valid_d;
      mw_regwen_q  <= mw_regwen_d;
      mw_halt_q    <= mw_halt_d;
      mw_dest_q    <= mw_dest_d;
      mw_wdat_q    <= mw_wdat_d;
    end
  end

  assign mw_valid  = mw_valid_q;
  assign mw_regwen = mw_regwen_q;
  assign mw_halt   = mw_halt_q;
  assign mw_dest   = mw_dest_q;
  assign mw_wdat   = mw_wdat_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage. Each instruction is held in
// EX/MEM for as many cycles as its ihit/dhit pattern needs; the expected
// commit is queued at issue and checked by an independent MEM/WB monitor.
`timescale 1ns/1ps
module tb_mem_stage;

  localparam int W = 32;
  localparam int R = 5;

  localparam int K_ALU  = 0;
  localparam int K_LW   = 1;
  localparam int K_SW   = 2;
  localparam int K_LL   = 3;
  localparam int K_SC   = 4;
  localparam int K_JAL  = 5;
  localparam int K_BUB  = 6;
  localparam int K_HALT = 7;

  logic         CLK = 1'b0;
  logic         nrst;
  logic         ihit, em_valid, dhit, llinv;
  logic [W-1:0] em_aluout, em_store, em_npc, dmemload, llinv_addr;
  logic [R-1:0] em_dest;
  logic         em_dren, em_dwen, em_ll, em_sc;
  logic         em_regwen, em_memtoreg, em_jal, em_halt;
  logic         dmemREN, dmemWEN, mem_stall;
  logic [W-1:0] dmemaddr, dmemstore;
  logic         mw_valid, mw_regwen, mw_halt;
  logic [R-1:0] mw_dest;
  logic [W-1:0] mw_wdat;

  always #5 CLK = ~CLK;

  mem_stage #(.WORD_W(W), .REG_W(R)) dut (
    .CLK(CLK), .nrst(nrst), .ihit(ihit), .em_valid(em_valid),
    .em_aluout(em_aluout), .em_store(em_store), .em_npc(em_npc),
    .em_dest(em_dest), .em_dren(em_dren), .em_dwen(em_dwen),
    .em_ll(em_ll), .em_sc(em_sc), .em_regwen(em_regwen),
    .em_memtoreg(em_memtoreg), .em_jal(em_jal), .em_halt(em_halt),
    .dhit(dhit), .dmemload(dmemload), .llinv(llinv),
    .llinv_addr(llinv_addr), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .mem_stall(mem_stall),
    .mw_valid(mw_valid), .mw_regwen(mw_regwen), .mw_halt(mw_halt),
    .mw_dest(mw_dest), .mw_wdat(mw_wdat)
  );

  typedef struct packed {
    logic         valid;
    logic [W-1:0] alu;
    logic [W-1:0] store;
    logic [W-1:0] npc;
    logic [R-1:0] dest;
    logic         dren, dwen, ll, sc, regwen, memtoreg, jal, halt;
  } instr_t;

  typedef struct packed {
    int           cyc;
    logic [R-1:0] dest;
    logic [W-1:0] wdat;
    logic         regwen;
    logic         halt;
  } exp_t;

  exp_t         sbq[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  int           cyc   = 0;

  // Architectural view of the link register and halt flag.
  logic         m_link_v;
  logic [W-1:0] m_link_a;
  logic         m_halt;
  logic [W-1:0] addr_tab [4];

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  function automatic bit ih(input logic [31:0] m, input int c);
    if (c >= 8) return 1'b1;
    return m[c];
  endfunction

  function automatic instr_t mk(input int kind, input logic [W-1:0] addr);
    instr_t t;
    logic [31:0] r;
    t = '0;
    r = $urandom;
    t.valid = 1'b1;
    t.alu   = addr;
    t.store = $urandom;
    t.npc   = $urandom;
    t.dest  = r[R-1:0];
    case (kind)
      K_ALU:  t.regwen = 1'b1;
      K_LW:   begin t.dren = 1'b1; t.memtoreg = 1'b1; t.regwen = 1'b1; end
      K_SW:   t.dwen = 1'b1;
      K_LL:   begin t.dren = 1'b1; t.ll = 1'b1; t.memtoreg = 1'b1; t.regwen = 1'b1; end
      K_SC:   begin t.dwen = 1'b1; t.sc = 1'b1; t.regwen = 1'b1; end
      K_JAL:  begin t.jal = 1'b1; t.regwen = 1'b1; end
      K_HALT: t.halt = 1'b1;
      default: begin
        t.valid  = 1'b0;
        t.dren   = r[8];
        t.dwen   = r[9];
        t.regwen = r[10];
        t.halt   = r[11];
      end
    endcase
    return t;
  endfunction

  // Present one instruction until it commits; queue the expected commit.
  task automatic run_instr(input instr_t in, input int d, input logic [31:0] ihmask,
                           input logic [W-1:0] ldata, input bit inv_en, input logic [W-1:0] inv_addr);
    logic sc_ok, rd, wr, memop, inv;
    int   commit;
    exp_t e;
    inv    = inv_en & ~in.sc;
    sc_ok  = m_link_v && (m_link_a == in.alu);
    rd     = in.valid & in.dren;
    wr     = in.valid & ((in.dwen & ~in.sc) | (in.sc & sc_ok));
    memop  = rd | wr;
    commit = memop ? d : 0;
    while (!ih(ihmask, commit)) commit++;
    for (int c = 0; c <= commit; c++) begin
      @(negedge CLK);
      em_valid    = in.valid;    em_aluout = in.alu;   em_store  = in.store;
      em_npc      = in.npc;      em_dest   = in.dest;  em_dren   = in.dren;
      em_dwen     = in.dwen;     em_ll     = in.ll;    em_sc     = in.sc;
      em_regwen   = in.regwen;   em_memtoreg = in.memtoreg;
      em_jal      = in.jal;      em_halt   = in.halt;
      ihit        = ih(ihmask, c);
      dhit        = memop && (c == d);
      dmemload    = (c == d) ? ldata : $urandom;
      llinv       = inv && (c == 0);
      llinv_addr  = inv_addr;
      #1;
      chk("dmemREN", dmemREN, rd && (c <= d));
      chk("dmemWEN", dmemWEN, wr && (c <= d));
      chk("mem_stall", mem_stall, memop && (c < d));
      chk("dmemaddr", dmemaddr, in.alu);
      chk("dmemstore", dmemstore, in.store);
      if (c == commit && in.valid) begin
        e.cyc    = cyc + 1;
        e.dest   = in.dest;
        e.regwen = in.regwen;
        e.halt   = m_halt | in.halt;
        if (in.memtoreg)  e.wdat = ldata;
        else if (in.jal)  e.wdat = in.npc;
        else if (in.sc)   e.wdat = {31'd0, sc_ok};
        else              e.wdat = in.alu;
        sbq.push_back(e);
      end
    end
    if (inv && (inv_addr == m_link_a)) m_link_v = 1'b0;
    if (in.valid) begin
      if (in.ll) begin
        m_link_v = 1'b1;
        m_link_a = in.alu;
      end else if (in.sc) begin
        m_link_v = 1'b0;
      end else if (in.dwen && (in.alu == m_link_a)) begin
        m_link_v = 1'b0;
      end
      if (in.halt) m_halt = 1'b1;
    end
  endtask

  // Monitor: every committed MEM/WB entry must match the head of the queue.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      cyc++;
      #1;
      if (mw_valid === 1'b1) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_commit: mw_valid=1 at cycle %0d, required no commit", cyc);
        end else begin
          e = sbq.pop_front();
          chk("commit_cycle", cyc, e.cyc);
          chk("mw_dest", mw_dest, e.dest);
          chk("mw_wdat", mw_wdat, e.wdat);
          chk("mw_regwen", mw_regwen, e.regwen);
          chk("mw_halt", mw_halt, e.halt);
          $display("commit cycle %0d dest %0d wdat %h regwen %0d halt %0d",
                   cyc, mw_dest, mw_wdat, mw_regwen, mw_halt);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running at 5000000 ns, required finish");
    $fatal(1, "watchdog expired");
  end

  // Reset while a load sits in DONE, then confirm everything restarts cleanly.
  task automatic reset_mid_done();
    instr_t t;
    run_instr(mk(K_LL, 32'h80), 0, 32'hFFFF_FFFF, $urandom, 1'b0, '0);
    @(negedge CLK);
    em_valid = 1'b1; em_aluout = 32'h40; em_dren = 1'b1; em_dwen = 1'b0;
    em_ll = 1'b0; em_sc = 1'b0; em_memtoreg = 1'b1; em_regwen = 1'b1;
    em_jal = 1'b0; em_halt = 1'b0; llinv = 1'b0;
    ihit = 1'b0; dhit = 1'b1; dmemload = 32'h1234;
    @(negedge CLK);
    dhit = 1'b0; dmemload = $urandom;
    #1;
    chk("done_dmemREN", dmemREN, 1'b0);
    chk("done_mem_stall", mem_stall, 1'b0);
    #2;
    nrst = 1'b0;
    em_valid = 1'b0;
    #1;
    chk("rst_mw_valid", mw_valid, 1'b0);
    chk("rst_mw_regwen", mw_regwen, 1'b0);
    chk("rst_mw_halt", mw_halt, 1'b0);
    chk("rst_mw_dest", mw_dest, '0);
    chk("rst_mw_wdat", mw_wdat, '0);
    chk("rst_dmemREN", dmemREN, 1'b0);
    chk("rst_dmemWEN", dmemWEN, 1'b0);
    chk("rst_mem_stall", mem_stall, 1'b0);
    m_link_v = 1'b0;
    m_link_a = '0;
    m_halt   = 1'b0;
    @(negedge CLK);
    nrst = 1'b1;
    run_instr(mk(K_SC, 32'h80), 1, 32'hFFFF_FFFF, '0, 1'b0, '0);
    run_instr(mk(K_LW, 32'h40), 2, 32'hFFFF_FFFF, $urandom, 1'b0, '0);
  endtask

  initial begin
    instr_t t;
    int     kind, d;
    logic [31:0] r;

    addr_tab[0] = 32'h80; addr_tab[1] = 32'h84;
    addr_tab[2] = 32'h40; addr_tab[3] = 32'hC0;
    m_link_v = 1'b0; m_link_a = '0; m_halt = 1'b0;
    nrst = 1'b0; ihit = 1'b0; dhit = 1'b0; llinv = 1'b0; llinv_addr = '0;
    em_valid = 1'b0; em_aluout = 32'h80; em_store = '0; em_npc = '0; em_dest = '0;
    em_dren = 1'b1; em_dwen = 1'b1; em_ll = 1'b0; em_sc = 1'b0;
    em_regwen = 1'b1; em_memtoreg = 1'b0; em_jal = 1'b0; em_halt = 1'b1;
    dmemload = '0;
    repeat (3) @(negedge CLK);
    #1;
    chk("reset_mw_valid", mw_valid, 1'b0);
    chk("reset_mw_regwen", mw_regwen, 1'b0);
    chk("reset_mw_halt", mw_halt, 1'b0);
    chk("reset_mw_dest", mw_dest, '0);
    chk("reset_mw_wdat", mw_wdat, '0);
    chk("reset_dmemREN", dmemREN, 1'b0);
    chk("reset_dmemWEN", dmemWEN, 1'b0);
    chk("reset_mem_stall", mem_stall, 1'b0);
    @(negedge CLK);
    nrst = 1'b1;

    // Directed cases.
    t = mk(K_LW, 32'h40); t.dest = 5'd7;
    run_instr(t, 2, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 1'b0, '0);
    run_instr(mk(K_LW, 32'h44), 0, 32'h0000_0004, 32'hCAFE_F00D, 1'b0, '0);
    run_instr(mk(K_LL, 32'h80), 1, 32'hFFFF_FFFF, 32'h1111_2222, 1'b0, '0);
    run_instr(mk(K_SC, 32'h80), 1, 32'hFFFF_FFFF, '0, 1'b0, '0);
    run_instr(mk(K_SC, 32'h80), 1, 32'hFFFF_FFFF, '0, 1'b0, '0);
    run_instr(mk(K_LL, 32'h80), 0, 32'hFFFF_FFFF, 32'h3333_4444, 1'b0, '0);
    run_instr(mk(K_ALU, 32'h10), 0, 32'hFFFF_FFFF, '0, 1'b1, 32'h80);
    run_instr(mk(K_SC, 32'h80), 0, 32'hFFFF_FFFF, '0, 1'b0, '0);
    run_instr(mk(K_LL, 32'h80), 0, 32'hFFFF_FFFF, 32'h5555_6666, 1'b0, '0);
    run_instr(mk(K_ALU, 32'h10), 0, 32'hFFFF_FFFF, '0, 1'b1, 32'h84);
    run_instr(mk(K_SC, 32'h80), 2, 32'hFFFF_FFFF, '0, 1'b0, '0);
    t = mk(K_JAL, 32'h200); t.npc = 32'h104;
    run_instr(t, 0, 32'hFFFF_FFFF, '0, 1'b0, '0);

    // Randomized stream with a reset in the middle.
    for (int i = 0; i < 220; i++) begin
      if (i == 110) reset_mid_done();
      kind = $urandom_range(0, 6);
      r = $urandom;
      if (kind == K_SC && r[0] && m_link_v)
        t = mk(kind, m_link_a);
      else if (kind == K_ALU || kind == K_JAL || kind == K_BUB)
        t = mk(kind, $urandom);
      else
        t = mk(kind, addr_tab[r[2:1]]);
      d = $urandom_range(0, 3);
      run_instr(t, d, $urandom | $urandom, $urandom, (r[5:4] == 2'b00), addr_tab[r[7:6]]);
    end

    // Halt is sticky through later bubbles.
    run_instr(mk(K_HALT, 32'h0), 0, 32'hFFFF_FFFF, '0, 1'b0, '0);
    for (int i = 0; i < 3; i++)
      run_instr(mk(K_BUB, 32'h0), 0, 32'hFFFF_FFFF, '0, 1'b0, '0);
    @(negedge CLK);
    em_valid = 1'b0; ihit = 1'b1; dhit = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    chk("halt_sticky", mw_halt, 1'b1);
    chk("halt_bubble_valid", mw_valid, 1'b0);
    chk("scoreboard_drained", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
